// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshakes (ports F and H), status and SRAM pin bundle
// for sram_arbiter. slave = arbiter side, master = requester/pad side.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 18
);
    localparam int unsigned DATA_W = 16;

    // Fetch port (read-only)
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              f_ack;

    // Host port (read/write)
    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic [DATA_W-1:0] h_rdata;
    logic              h_ack;

    // Status
    logic              busy;

    // SRAM pins (tristate lives in the top level)
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dout;
    logic              sram_doe;
    logic [DATA_W-1:0] sram_din;
    logic              sram_cen;
    logic              sram_oen;
    logic              sram_wen;

    modport slave (
        input  f_req, f_addr, h_req, h_we, h_addr, h_wdata, sram_din,
        output f_rdata, f_ack, h_rdata, h_ack, busy,
               sram_addr, sram_dout, sram_doe, sram_cen, sram_oen, sram_wen
    );

    modport master (
        output f_req, f_addr, h_req, h_we, h_addr, h_wdata, sram_din,
        input  f_rdata, f_ack, h_rdata, h_ack, busy,
               sram_addr, sram_dout, sram_doe, sram_cen, sram_oen, sram_wen
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit asynchronous SRAM between the instruction-fetch
// port F (read-only) and the host port H (read/write). Each access runs
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> FINISH with every output registered.
// Optional feature macro: SRAM_RR_ARB_EN selects round-robin arbitration;
// when undefined, host always wins a tie and no pointer register exists.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic          clk,
    input  logic          rstn,
    sram_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             gnt_h;      // port owning the current access: 1 = H, 0 = F
    logic             acc_we;     // current access is a write

    logic             grant_any_c;
    logic             grant_h_c;

`ifdef SRAM_RR_ARB_EN
    logic             last_h;     // port granted most recently: 1 = H, 0 = F

    // Tie goes to the port that was not granted most recently.
    always_comb begin
        grant_any_c = bus.f_req | bus.h_req;
        grant_h_c   = bus.h_req & (~bus.f_req | ~last_h);
    end

    // Round-robin pointer moves only when a grant is issued.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_h <= 1'b0;
        end else if ((state == IDLE) && grant_any_c) begin
            last_h <= grant_h_c;
        end
    end
`else
    // Fixed priority: host over fetch.
    always_comb begin
        grant_any_c = bus.f_req | bus.h_req;
        grant_h_c   = bus.h_req;
    end
`endif

    // Access sequencer: state, wait counter, strobes, data capture and acks.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            gnt_h         <= 1'b0;
            acc_we        <= 1'b0;
            bus.sram_cen  <= 1'b1;
            bus.sram_oen  <= 1'b1;
            bus.sram_wen  <= 1'b1;
            bus.sram_doe  <= 1'b0;
            bus.sram_addr <= '0;
            bus.sram_dout <= '0;
            bus.f_ack     <= 1'b0;
            bus.h_ack     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.f_rdata   <= '0;
            bus.h_rdata   <= '0;
        end else begin
            bus.f_ack <= 1'b0;
            bus.h_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any_c) begin
                        state        <= SETUP;
                        bus.busy     <= 1'b1;
                        bus.sram_cen <= 1'b0;
                        gnt_h        <= grant_h_c;
                        if (grant_h_c) begin
                            acc_we        <= bus.h_we;
                            bus.sram_addr <= bus.h_addr;
                            bus.sram_doe  <= bus.h_we;
                            if (bus.h_we) begin
                                bus.sram_dout <= bus.h_wdata;
                            end
                        end else begin
                            acc_we        <= 1'b0;
                            bus.sram_addr <= bus.f_addr;
                            bus.sram_doe  <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    state        <= ACCESS;
                    wait_cnt     <= WAIT_LOAD;
                    bus.sram_oen <= acc_we;
                    bus.sram_wen <= ~acc_we;
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        state        <= FINISH;
                        bus.sram_oen <= 1'b1;
                        bus.sram_wen <= 1'b1;
                        if (gnt_h) begin
                            bus.h_ack <= 1'b1;
                            if (!acc_we) begin
                                bus.h_rdata <= bus.sram_din;
                            end
                        end else begin
                            bus.f_ack   <= 1'b1;
                            bus.f_rdata <= bus.sram_din;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                FINISH: begin
                    // Address and doe held through this cycle for write hold time.
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.sram_cen <= 1'b1;
                    bus.sram_doe <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with WAIT_CYCLES=2 (dut2)
// and WAIT_CYCLES=1 (dut1) sharing a behavioural SRAM model.
module tb_sram_arbiter;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned MEM_D  = 1024;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W)) b2 ();
    sram_arbiter_if #(.ADDR_W(ADDR_W)) b1 ();

    sram_arbiter #(.WAIT_CYCLES(2), .ADDR_W(ADDR_W)) dut2 (
        .clk (clk),
        .rstn(rstn),
        .bus (b2.slave)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(ADDR_W)) dut1 (
        .clk (clk),
        .rstn(rstn),
        .bus (b1.slave)
    );

    // Behavioural SRAM: reset loads a known pattern; writes while cen, wen low and doe high.
    logic [15:0] mem [MEM_D];

    function automatic logic [15:0] pat(input logic [ADDR_W-1:0] a);
        return 16'h5A00 ^ 16'(a);
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(MEM_D); i++) mem[i] <= pat(ADDR_W'(i));
        end else begin
            if (!b2.sram_cen && !b2.sram_wen && b2.sram_doe) mem[b2.sram_addr[9:0]] <= b2.sram_dout;
            if (!b1.sram_cen && !b1.sram_wen && b1.sram_doe) mem[b1.sram_addr[9:0]] <= b1.sram_dout;
        end
    end

    assign b2.sram_din = b2.sram_oen ? 16'h0000 : mem[b2.sram_addr[9:0]];
    assign b1.sram_din = b1.sram_oen ? 16'h0000 : mem[b1.sram_addr[9:0]];

    typedef struct packed {
        logic        is_h;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_h_rdata;
    logic [15:0] exp_f_rdata;

    task automatic test_reset();
        rstn = 1'b0;
        b2.f_req = 1'b0; b2.f_addr = '0; b2.h_req = 1'b0; b2.h_we = 1'b0; b2.h_addr = '0; b2.h_wdata = '0;
        b1.f_req = 1'b0; b1.f_addr = '0; b1.h_req = 1'b0; b1.h_we = 1'b0; b1.h_addr = '0; b1.h_wdata = '0;
        exp_h_rdata = 16'h0000;
        exp_f_rdata = 16'h0000;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        n_checks++;
        if ({b2.sram_cen, b2.sram_oen, b2.sram_wen, b2.sram_doe, b2.busy, b2.f_ack, b2.h_ack} !== 7'b1110000)
            $display("FAIL reset_ctrl: got %b expected 1110000",
                     {b2.sram_cen, b2.sram_oen, b2.sram_wen, b2.sram_doe, b2.busy, b2.f_ack, b2.h_ack});
        else n_pass++;
        n_checks++;
        if ({b2.sram_addr, b2.sram_dout, b2.f_rdata, b2.h_rdata} !== '0)
            $display("FAIL reset_data: addr=%h dout=%h f_rdata=%h h_rdata=%h expected all zero",
                     b2.sram_addr, b2.sram_dout, b2.f_rdata, b2.h_rdata);
        else n_pass++;
        n_checks++;
        if ({b1.sram_cen, b1.sram_oen, b1.sram_wen, b1.sram_doe, b1.busy} !== 5'b11100)
            $display("FAIL reset_ctrl_w1: got %b expected 11100",
                     {b1.sram_cen, b1.sram_oen, b1.sram_wen, b1.sram_doe, b1.busy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({b2.busy, b2.sram_cen} !== 2'b01)
            $display("FAIL idle_after_reset: busy,cen got %b expected 01", {b2.busy, b2.sram_cen});
        else n_pass++;
    endtask

    task automatic test_host_write();
        int   ack_at = -1;
        int   wen_low = 0, oen_low = 0, doe_hi = 0, bus_bad = 0, stray = 0;
        exp_t e;
        b2.h_req = 1'b1; b2.h_we = 1'b1; b2.h_addr = 18'h00123; b2.h_wdata = 16'hBEEF;
        sb.push_back('{is_h: 1'b1, data: exp_h_rdata});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) begin
                b2.h_addr  = 18'h3FFFF;
                b2.h_wdata = 16'h0000;
            end
            if (!b2.sram_wen) wen_low++;
            if (!b2.sram_oen) oen_low++;
            if (b2.sram_doe) doe_hi++;
            if (!b2.sram_cen && b2.sram_addr !== 18'h00123) bus_bad++;
            if (b2.sram_doe && b2.sram_dout !== 16'hBEEF) bus_bad++;
            if (b2.f_ack) stray++;
            if (b2.h_ack) begin
                if (ack_at < 0) ack_at = k;
                b2.h_req = 1'b0;
                n_checks++;
                if (sb.size() == 0) $display("FAIL hw_sb: h_ack with no pending access");
                else begin
                    e = sb.pop_front();
                    if ({1'b1, b2.h_rdata} !== {e.is_h, e.data})
                        $display("FAIL hw_sb: got port_h=1 rdata=%h expected port_h=%b rdata=%h", b2.h_rdata, e.is_h, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (ack_at !== 4) $display("FAIL hw_ack_cycle: got %0d expected 4", ack_at); else n_pass++;
        n_checks++; if (wen_low !== 2) $display("FAIL hw_wen_low: got %0d expected 2", wen_low); else n_pass++;
        n_checks++; if (doe_hi !== 4) $display("FAIL hw_doe_cycles: got %0d expected 4", doe_hi); else n_pass++;
        n_checks++; if (oen_low !== 0) $display("FAIL hw_oen_low: got %0d expected 0", oen_low); else n_pass++;
        n_checks++; if (bus_bad !== 0) $display("FAIL hw_addr_data: got %0d bad cycles expected 0", bus_bad); else n_pass++;
        n_checks++; if (stray !== 0) $display("FAIL hw_f_ack: got %0d expected 0", stray); else n_pass++;
        n_checks++; if (mem[10'h123] !== 16'hBEEF) $display("FAIL hw_mem: got %h expected beef", mem[10'h123]); else n_pass++;
    endtask

    task automatic test_fetch_read();
        int   ack_at = -1;
        int   oen_low = 0, wen_low = 0, doe_hi = 0, stray = 0;
        exp_t e;
        b2.f_req = 1'b1; b2.f_addr = 18'h00123;
        exp_f_rdata = 16'hBEEF;
        sb.push_back('{is_h: 1'b0, data: exp_f_rdata});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!b2.sram_oen) oen_low++;
            if (!b2.sram_wen) wen_low++;
            if (b2.sram_doe) doe_hi++;
            if (b2.h_ack) stray++;
            if (b2.f_ack) begin
                if (ack_at < 0) ack_at = k;
                b2.f_req = 1'b0;
                n_checks++;
                if (sb.size() == 0) $display("FAIL fr_sb: f_ack with no pending access");
                else begin
                    e = sb.pop_front();
                    if ({1'b0, b2.f_rdata} !== {e.is_h, e.data})
                        $display("FAIL fr_sb: got port_h=0 rdata=%h expected port_h=%b rdata=%h", b2.f_rdata, e.is_h, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (ack_at !== 4) $display("FAIL fr_ack_cycle: got %0d expected 4", ack_at); else n_pass++;
        n_checks++; if (oen_low !== 2) $display("FAIL fr_oen_low: got %0d expected 2", oen_low); else n_pass++;
        n_checks++; if (wen_low !== 0) $display("FAIL fr_wen_low: got %0d expected 0", wen_low); else n_pass++;
        n_checks++; if (doe_hi !== 0) $display("FAIL fr_doe: got %0d expected 0", doe_hi); else n_pass++;
        n_checks++; if (stray !== 0) $display("FAIL fr_h_ack: got %0d expected 0", stray); else n_pass++;
        n_checks++; if (b2.h_rdata !== exp_h_rdata) $display("FAIL fr_h_rdata: got %h expected %h", b2.h_rdata, exp_h_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          acks = 0, dual = 0;
        exp_t        e;
        logic        obs_h;
        logic [15:0] obs_d;
        b2.f_addr = 18'h00010; b2.h_addr = 18'h00020; b2.h_we = 1'b0;
        b2.f_req = 1'b1; b2.h_req = 1'b1;
`ifdef SRAM_RR_ARB_EN
        sb.push_back('{is_h: 1'b1, data: pat(18'h00020)});
        sb.push_back('{is_h: 1'b0, data: pat(18'h00010)});
        sb.push_back('{is_h: 1'b1, data: pat(18'h00020)});
        sb.push_back('{is_h: 1'b0, data: pat(18'h00010)});
        exp_f_rdata = pat(18'h00010);
`else
        for (int i = 0; i < 4; i++) sb.push_back('{is_h: 1'b1, data: pat(18'h00020)});
`endif
        exp_h_rdata = pat(18'h00020);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (b2.f_ack && b2.h_ack) dual++;
            if (b2.f_ack || b2.h_ack) begin
                obs_h = b2.h_ack;
                obs_d = b2.h_ack ? b2.h_rdata : b2.f_rdata;
                acks++;
                n_checks++;
                if (sb.size() == 0) $display("FAIL b2b_sb: ack %0d with no pending access", acks);
                else begin
                    e = sb.pop_front();
                    if ({obs_h, obs_d} !== {e.is_h, e.data})
                        $display("FAIL b2b_order: ack %0d got port_h=%b rdata=%h expected port_h=%b rdata=%h",
                                 acks, obs_h, obs_d, e.is_h, e.data);
                    else n_pass++;
                end
                if (acks == 4) begin
                    b2.f_req = 1'b0;
                    b2.h_req = 1'b0;
                end
            end
        end
        n_checks++; if (acks !== 4) $display("FAIL b2b_count: got %0d acks expected 4", acks); else n_pass++;
        n_checks++; if (dual !== 0) $display("FAIL b2b_dual_ack: got %0d expected 0", dual); else n_pass++;
        n_checks++; if (b2.f_rdata !== exp_f_rdata) $display("FAIL b2b_f_rdata: got %h expected %h", b2.f_rdata, exp_f_rdata); else n_pass++;
    endtask

    task automatic test_held_request();
        int   acks = 0, last_ack = -1, first_ack = -1, hi_run = 0, gaps = 0, wide = 0;
        logic seen_low = 1'b0, prev_ack = 1'b0;
        exp_t e;
        b2.f_addr = 18'h00060; b2.f_req = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back('{is_h: 1'b0, data: pat(18'h00060)});
        exp_f_rdata = pat(18'h00060);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (b2.sram_cen) hi_run++;
            else begin
                if (seen_low && hi_run > 0) begin
                    gaps++;
                    n_checks++;
                    if (hi_run !== 1) $display("FAIL held_cen_gap: got %0d high cycles expected 1", hi_run);
                    else n_pass++;
                end
                hi_run   = 0;
                seen_low = 1'b1;
            end
            if (b2.f_ack && prev_ack) wide++;
            prev_ack = b2.f_ack;
            if (b2.f_ack) begin
                acks++;
                if (first_ack < 0) first_ack = k;
                if (last_ack > 0) begin
                    n_checks++;
                    if (k - last_ack !== 5) $display("FAIL held_interval: got %0d expected 5", k - last_ack);
                    else n_pass++;
                end
                last_ack = k;
                n_checks++;
                if (sb.size() == 0) $display("FAIL held_sb: f_ack with no pending access");
                else begin
                    e = sb.pop_front();
                    if ({1'b0, b2.f_rdata} !== {e.is_h, e.data})
                        $display("FAIL held_sb: got port_h=0 rdata=%h expected port_h=%b rdata=%h", b2.f_rdata, e.is_h, e.data);
                    else n_pass++;
                end
                if (acks == 4) b2.f_req = 1'b0;
            end
        end
        n_checks++; if (first_ack !== 4) $display("FAIL held_first: got %0d expected 4", first_ack); else n_pass++;
        n_checks++; if (acks !== 4) $display("FAIL held_count: got %0d expected 4", acks); else n_pass++;
        n_checks++; if (gaps !== 3) $display("FAIL held_gaps: got %0d expected 3", gaps); else n_pass++;
        n_checks++; if (wide !== 0) $display("FAIL held_wide_ack: got %0d expected 0", wide); else n_pass++;
    endtask

    task automatic test_wait1();
        int   ack_at = -1, oen_low = 0;
        exp_t e;
        b1.h_req = 1'b1; b1.h_we = 1'b0; b1.h_addr = 18'h00070;
        sb.push_back('{is_h: 1'b1, data: pat(18'h00070)});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!b1.sram_oen) oen_low++;
            if (b1.h_ack) begin
                if (ack_at < 0) ack_at = k;
                b1.h_req = 1'b0;
                n_checks++;
                if (sb.size() == 0) $display("FAIL w1_sb: h_ack with no pending access");
                else begin
                    e = sb.pop_front();
                    if ({1'b1, b1.h_rdata} !== {e.is_h, e.data})
                        $display("FAIL w1_sb: got port_h=1 rdata=%h expected port_h=%b rdata=%h", b1.h_rdata, e.is_h, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (ack_at !== 3) $display("FAIL w1_ack_cycle: got %0d expected 3", ack_at); else n_pass++;
        n_checks++; if (oen_low !== 1) $display("FAIL w1_oen_low: got %0d expected 1", oen_low); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int   ack_at = -1, stray = 0;
        exp_t e;
        b2.h_req = 1'b1; b2.h_we = 1'b1; b2.h_addr = 18'h00040; b2.h_wdata = 16'h1234;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({b2.sram_cen, b2.sram_wen, b2.sram_doe} !== 3'b001)
            $display("FAIL rmw_in_access: cen,wen,doe got %b expected 001", {b2.sram_cen, b2.sram_wen, b2.sram_doe});
        else n_pass++;
        rstn = 1'b0;
        b2.h_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_h_rdata = 16'h0000;
        exp_f_rdata = 16'h0000;
        n_checks++;
        if ({b2.sram_cen, b2.sram_oen, b2.sram_wen, b2.sram_doe, b2.busy, b2.f_ack, b2.h_ack} !== 7'b1110000)
            $display("FAIL rmw_reset_ctrl: got %b expected 1110000",
                     {b2.sram_cen, b2.sram_oen, b2.sram_wen, b2.sram_doe, b2.busy, b2.f_ack, b2.h_ack});
        else n_pass++;
        n_checks++;
        if ({b2.sram_addr, b2.f_rdata, b2.h_rdata} !== '0)
            $display("FAIL rmw_reset_data: addr=%h f_rdata=%h h_rdata=%h expected all zero", b2.sram_addr, b2.f_rdata, b2.h_rdata);
        else n_pass++;
        repeat (3) begin
            @(negedge clk);
            if (b2.h_ack || b2.f_ack || b2.busy) stray++;
        end
        n_checks++; if (stray !== 0) $display("FAIL rmw_no_ack: got %0d active cycles expected 0", stray); else n_pass++;
        b2.h_req = 1'b1; b2.h_we = 1'b0; b2.h_addr = 18'h00050;
        exp_h_rdata = pat(18'h00050);
        sb.push_back('{is_h: 1'b1, data: exp_h_rdata});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (b2.h_ack) begin
                if (ack_at < 0) ack_at = k;
                b2.h_req = 1'b0;
                n_checks++;
                if (sb.size() == 0) $display("FAIL rmw_sb: h_ack with no pending access");
                else begin
                    e = sb.pop_front();
                    if ({1'b1, b2.h_rdata} !== {e.is_h, e.data})
                        $display("FAIL rmw_sb: got port_h=1 rdata=%h expected port_h=%b rdata=%h", b2.h_rdata, e.is_h, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (ack_at !== 4) $display("FAIL rmw_after_ack: got %0d expected 4", ack_at); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_fetch_read();
        test_back_to_back();
        test_held_request();
        test_wait1();
        test_reset_mid_write();
        n_checks++;
        if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
